// File: rtl/pipe_skid_stage.sv
// Generic inter-stage pipeline register with valid/ready handshake and a two-entry skid buffer.
// Optional stall counter enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage #(
    parameter int DATA_W     = 16,
    parameter int NUM_FIELDS = 3,
    parameter int PKT_W      = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PKT_W-1:0]             in_pkt,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    input  logic                         flush,
    input  logic                         bubble,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PKT_W-1:0]             out_pkt,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data,
    output logic [15:0]                  stall_cycles
);

    localparam int DW_ALL = NUM_FIELDS * DATA_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PKT_W-1:0]    main_pkt_q, main_pkt_d;
    logic [DW_ALL-1:0]   main_data_q, main_data_d;
    logic [PKT_W-1:0]    skid_pkt_q, skid_pkt_d;
    logic [DW_ALL-1:0]   skid_data_q, skid_data_d;
    logic                enq_s;
    logic                deq_s;

    // in_ready depends only on registered state, so no path from out_ready reaches upstream.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY) && !bubble;
    assign out_pkt   = out_valid ? main_pkt_q  : {PKT_W{1'b0}};
    assign out_data  = out_valid ? main_data_q : {DW_ALL{1'b0}};
    assign enq_s     = in_valid && in_ready;
    assign deq_s     = out_valid && out_ready;

    // Next-state and entry update for the occupancy FSM.
    always_comb begin
        state_d     = state_q;
        main_pkt_d  = main_pkt_q;
        main_data_d = main_data_q;
        skid_pkt_d  = skid_pkt_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_pkt_d  = {PKT_W{1'b0}};
            main_data_d = {DW_ALL{1'b0}};
            skid_pkt_d  = {PKT_W{1'b0}};
            skid_data_d = {DW_ALL{1'b0}};
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (enq_s) begin
                        main_pkt_d  = in_pkt;
                        main_data_d = in_data;
                        state_d     = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (enq_s && deq_s) begin
                        main_pkt_d  = in_pkt;
                        main_data_d = in_data;
                    end else if (enq_s) begin
                        skid_pkt_d  = in_pkt;
                        skid_data_d = in_data;
                        state_d     = ST_FULL;
                    end else if (deq_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (deq_s) begin
                        main_pkt_d  = skid_pkt_q;
                        main_data_d = skid_data_q;
                        state_d     = ST_ONE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and entry registers; reset outranks flush and transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_pkt_q  <= {PKT_W{1'b0}};
            main_data_q <= {DW_ALL{1'b0}};
            skid_pkt_q  <= {PKT_W{1'b0}};
            skid_data_q <= {DW_ALL{1'b0}};
        end else begin
            state_q     <= state_d;
            main_pkt_q  <= main_pkt_d;
            main_data_q <= main_data_d;
            skid_pkt_q  <= skid_pkt_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of cycles where a held, unmasked entry is refused downstream.
    always_comb begin
        if (flush) begin
            stall_d = 16'h0000;
        end else if ((state_q != ST_EMPTY) && !bubble && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'h0001;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 16'h0000;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard-driven self-checking bench for pipe_skid_stage.
module tb_pipe_skid_stage;

    localparam int DATA_W     = 16;
    localparam int NUM_FIELDS = 3;
    localparam int PKT_W      = 32;
    localparam int DW_ALL     = NUM_FIELDS * DATA_W;

    typedef logic [PKT_W+DW_ALL-1:0] ent_t;

    logic              clk = 1'b0;
    logic              reset, in_valid, in_ready, flush, bubble, out_valid, out_ready;
    logic [PKT_W-1:0]  in_pkt, out_pkt;
    logic [DW_ALL-1:0] in_data, out_data;
    logic [15:0]       stall_cycles;

    ent_t sb_q[$];
    ent_t exp_e;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .PKT_W(PKT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pkt(in_pkt), .in_data(in_data), .flush(flush), .bubble(bubble),
        .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt),
        .out_data(out_data), .stall_cycles(stall_cycles)
    );

    function automatic logic [DW_ALL-1:0] mk_data(input logic [PKT_W-1:0] p);
        return {p[15:0] + 16'd3, p[15:0] ^ 16'h5A5A, ~p[15:0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_pkt    = 32'h0;
        in_data   = 48'h0;
        flush     = 1'b0;
        bubble    = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic drive(input logic [PKT_W-1:0] p);
        in_valid = 1'b1;
        in_pkt   = p;
        in_data  = mk_data(p);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
        chk_cnt++; if (out_pkt !== 32'h0) $display("FAIL reset_out_pkt got %h exp 0", out_pkt); else pass_cnt++;
        chk_cnt++; if (out_data !== 48'h0) $display("FAIL reset_out_data got %h exp 0", out_data); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else pass_cnt++;
        chk_cnt++; if (stall_cycles !== 16'h0) $display("FAIL reset_stall got %h exp 0", stall_cycles); else pass_cnt++;
        cyc();
    endtask

    task automatic test_streaming();
        logic [PKT_W-1:0] pk;
        idle_inputs();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pk = 32'h11 * (i + 1);
            if (i < 3) drive(pk); else in_valid = 1'b0;
            #1;
            chk_cnt++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready); else pass_cnt++;
            if (i > 0) begin
                chk_cnt++; if (out_valid !== 1'b1) $display("FAIL stream_out_valid[%0d] got %b exp 1", i, out_valid); else pass_cnt++;
                exp_e = sb_q.pop_front();
                chk_cnt++; if ({out_pkt, out_data} !== exp_e) $display("FAIL stream_out[%0d] got %h exp %h", i, {out_pkt, out_data}, exp_e); else pass_cnt++;
            end
            if (i < 3) sb_q.push_back({pk, mk_data(pk)});
            cyc();
        end
        #1;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_drained_valid got %b exp 0", out_valid); else pass_cnt++;
        chk_cnt++; if ({out_pkt, out_data} !== 80'h0) $display("FAIL stream_empty_not_stale got %h exp 0", {out_pkt, out_data}); else pass_cnt++;
        idle_inputs();
        cyc();
    endtask

    task automatic test_skid_fill();
        idle_inputs();
        drive(32'hA1);
        sb_q.push_back({32'hA1, mk_data(32'hA1)});
        cyc();
        drive(32'hA2);
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL skid_ready_one got %b exp 1", in_ready); else pass_cnt++;
        sb_q.push_back({32'hA2, mk_data(32'hA2)});
        cyc();
        drive(32'hA9);
        #1;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL skid_ready_full got %b exp 0", in_ready); else pass_cnt++;
        chk_cnt++; if (out_pkt !== 32'hA1) $display("FAIL skid_head got %h exp a1", out_pkt); else pass_cnt++;
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        exp_e = sb_q.pop_front();
        chk_cnt++; if ({out_pkt, out_data} !== exp_e) $display("FAIL skid_deq1 got %h exp %h", {out_pkt, out_data}, exp_e); else pass_cnt++;
        cyc();
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL skid_ready_after_deq got %b exp 1", in_ready); else pass_cnt++;
        exp_e = sb_q.pop_front();
        chk_cnt++; if ({out_pkt, out_data} !== exp_e) $display("FAIL skid_deq2 got %h exp %h", {out_pkt, out_data}, exp_e); else pass_cnt++;
        cyc();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL skid_full_rejected got %b exp 0", out_valid); else pass_cnt++;
        idle_inputs();
        cyc();
    endtask

    task automatic test_flush();
        idle_inputs();
        drive(32'hB1);
        cyc();
        drive(32'hB2);
        cyc();
        drive(32'hB3);
        flush = 1'b1;
        cyc();
        idle_inputs();
        sb_q.delete();
        out_ready = 1'b1;
        #1;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got %b exp 0", out_valid); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got %b exp 1", in_ready); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_cnt++; if (out_valid !== 1'b0 || out_pkt !== 32'h0) $display("FAIL flush_b3_seen[%0d] got %b/%h exp 0/0", i, out_valid, out_pkt); else pass_cnt++;
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_bubble();
        idle_inputs();
        in_valid = 1'b1;
        in_pkt   = 32'hC4;
        in_data  = {16'h0003, 16'h0002, 16'h0001};
        sb_q.push_back({32'hC4, 16'h0003, 16'h0002, 16'h0001});
        cyc();
        in_valid  = 1'b0;
        bubble    = 1'b1;
        out_ready = 1'b1;
        #1;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL bubble_valid got %b exp 0", out_valid); else pass_cnt++;
        chk_cnt++; if ({out_pkt, out_data} !== 80'h0) $display("FAIL bubble_mask got %h exp 0", {out_pkt, out_data}); else pass_cnt++;
        cyc();
        drive(32'hC5);
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bubble_in_ready got %b exp 1", in_ready); else pass_cnt++;
        sb_q.push_back({32'hC5, mk_data(32'hC5)});
        cyc();
        in_valid = 1'b0;
        bubble   = 1'b0;
        #1;
        chk_cnt++; if (out_valid !== 1'b1) $display("FAIL bubble_release_valid got %b exp 1", out_valid); else pass_cnt++;
        exp_e = sb_q.pop_front();
        chk_cnt++; if ({out_pkt, out_data} !== exp_e) $display("FAIL bubble_c4 got %h exp %h", {out_pkt, out_data}, exp_e); else pass_cnt++;
        cyc();
        exp_e = sb_q.pop_front();
        chk_cnt++; if ({out_pkt, out_data} !== exp_e) $display("FAIL bubble_c5 got %h exp %h", {out_pkt, out_data}, exp_e); else pass_cnt++;
        cyc();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL bubble_drained got %b exp 0", out_valid); else pass_cnt++;
        idle_inputs();
        cyc();
    endtask

    task automatic test_stall_cnt();
        idle_inputs();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(32'hD1);
        cyc();
        in_valid = 1'b0;
        repeat (5) cyc();
`ifdef PIPE_SKID_STALL_CNT_EN
        chk_cnt++; if (stall_cycles !== 16'd5) $display("FAIL stall_count got %0d exp 5", stall_cycles); else pass_cnt++;
`else
        chk_cnt++; if (stall_cycles !== 16'd0) $display("FAIL stall_tied got %0d exp 0", stall_cycles); else pass_cnt++;
`endif
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk_cnt++; if (stall_cycles !== 16'd0) $display("FAIL stall_flush got %0d exp 0", stall_cycles); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_flush_valid got %b exp 0", out_valid); else pass_cnt++;
        idle_inputs();
        cyc();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        drive(32'hE1);
        cyc();
        drive(32'hE2);
        cyc();
        drive(32'hE3);
        flush = 1'b1;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        idle_inputs();
        sb_q.delete();
        #1;
        chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL reset_mid got %b/%b exp 0/1", out_valid, in_ready); else pass_cnt++;
        chk_cnt++; if (out_pkt !== 32'h0) $display("FAIL reset_mid_pkt got %h exp 0", out_pkt); else pass_cnt++;
        cyc();
    endtask

    task automatic test_back_to_back();
        logic exp_ready, exp_valid;
        int   bad = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_pkt    = $urandom;
            in_data   = mk_data(in_pkt);
            out_ready = ($urandom_range(0, 2) != 0);
            bubble    = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            #1;
            exp_ready = (sb_q.size() < 2);
            exp_valid = (sb_q.size() != 0) && !bubble;
            chk_cnt++;
            if (in_ready !== exp_ready || out_valid !== exp_valid) begin
                bad++;
                if (bad < 10) $display("FAIL b2b_hs[%0d] got %b/%b exp %b/%b", i, in_ready, out_valid, exp_ready, exp_valid);
            end else pass_cnt++;
            if (exp_valid && out_ready) begin
                exp_e = sb_q.pop_front();
                chk_cnt++;
                if ({out_pkt, out_data} !== exp_e) begin
                    bad++;
                    if (bad < 10) $display("FAIL b2b_data[%0d] got %h exp %h", i, {out_pkt, out_data}, exp_e);
                end else pass_cnt++;
            end
            if (flush) sb_q.delete();
            else if (in_valid && exp_ready) sb_q.push_back({in_pkt, in_data});
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_streaming();
        test_skid_fill();
        test_flush();
        test_bubble();
        test_stall_cnt();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised successor to the fixed MEM/WB register: a generic inter-stage pipeline register for the lc3b pipeline with a valid/ready handshake in place of a raw stall.
- Holds one instruction packet plus NUM_FIELDS data words per entry.
- A two-entry skid buffer lets the upstream stage hand over one more instruction in the cycle the downstream stage stalls.
- Adds synchronous reset, flush and output bubble masking; drop-in between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 16, width of each data field (lc3b_word).
- NUM_FIELDS, 3, number of data fields carried per entry (e.g. alu, mem_data, br_address).
- PKT_W, 32, width of the instruction packet (lc3b_ipacket bit width).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents a valid entry.
- in_ready  output  1  stage can accept an entry this cycle.
- in_pkt  input  PKT_W  instruction packet from upstream.
- in_data  input  NUM_FIELDS*DATA_W  data fields; field k occupies bits [k*DATA_W +: DATA_W].
- flush  input  1  discard all held entries (branch mispredict / exception).
- bubble  input  1  mask the output and hold the contents this cycle.
- out_valid  output  1  valid entry presented downstream.
- out_ready  input  1  downstream accepts the entry.
- out_pkt  output  PKT_W  packet to downstream.
- out_data  output  NUM_FIELDS*DATA_W  data fields to downstream.
- stall_cycles  output  16  stall counter (see Optional Feature).

Behaviour:
- Storage
  - Two entries: main (head, drives outputs) and skid.
  - Occupancy state is one of EMPTY, ONE, FULL.
- Reset
  - On a rising edge with reset=1: state EMPTY, both entries' pkt and data = 0, stall_cycles = 0.
  - Resulting outputs: out_valid=0, out_pkt=0, out_data=0, in_ready=1.
  - Reset mid-operation discards all held entries and has priority over flush and all transfers.
- Handshake
  - in_ready = (state != FULL). It is a registered-state decode only, with no combinational path from out_ready.
  - enq = in_valid & in_ready.
  - deq = out_valid & out_ready, where out_valid = (state != EMPTY) & ~bubble.
- Transitions (no flush)
  - EMPTY: enq -> main = input, go to ONE.
  - ONE, enq & deq -> main = input, stay in ONE.
  - ONE, enq only -> skid = input, go to FULL.
  - ONE, deq only -> go to EMPTY.
  - FULL: deq -> main = skid, go to ONE. No enq is possible in FULL.
  - Order is strictly FIFO: entries leave in acceptance order.
- Latency: an entry accepted at edge N is visible on out_* after edge N (1 cycle) when the stage was EMPTY or ONE-with-dequeue.
- Flush
  - On a rising edge with flush=1: state EMPTY, entries zeroed.
  - An enq in the same cycle is dropped, even though in_ready may read 1.
  - A deq in the same cycle still completes downstream.
- Bubble
  - Purely combinational on the outputs: out_valid=0, out_pkt=0, out_data=0.
  - No dequeue occurs while bubble=1. Contents and state are unchanged except by enq.
- Outputs when state=EMPTY: out_pkt and out_data are 0, never stale.
- Unused entry registers hold their value; there is no X propagation after reset.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined
  - stall_cycles increments by 1 on every edge where state != EMPTY, bubble=0 and out_ready=0.
  - It saturates at 16'hFFFF.
  - It clears on reset or flush.
- Not defined: stall_cycles is tied to 16'h0 and no counter logic is built.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> out_valid=0, out_pkt=0, out_data=0, in_ready=1, stall_cycles=0.
- Streaming: out_ready=1, drive pkt 0x11,0x22,0x33 with in_valid=1 on consecutive cycles -> out_pkt shows 0x11,0x22,0x33 on the following cycles; in_ready stays 1.
- Skid fill: hold out_ready=0 and enqueue 0xA1 then 0xA2 -> state FULL, in_ready=0, out_pkt=0xA1. Then raise out_ready -> 0xA1 then 0xA2 are delivered and in_ready returns to 1 after the first deq.
- Flush with simultaneous enq: FULL with 0xB1/0xB2, assert flush and in_valid with 0xB3 -> next cycle out_valid=0, in_ready=1, and 0xB3 never appears.
- Bubble: state ONE holding pkt 0xC4 with data {16'h0003,16'h0002,16'h0001}, bubble=1, out_ready=1 -> out_valid=0 and all outputs 0. Drop bubble -> 0xC4 and its data reappear and are then dequeued.
- Stall counter (macro defined): hold one entry with out_ready=0 for 5 cycles -> stall_cycles=5. Flush -> stall_cycles=0.
